// File: rtl/led_display_sched_pkg.sv
// Shared definitions for the LED display scheduler.
// Contents:
//   sched_state_e  scheduler states (IDLE, PLAY, KEY, HOLD, ALERT)
//   SRC_*          disp_src owner codes reported to the display stage
//   BLINK_*        idle blink pattern values
//   max_int        helper used to size the shared ms down-counter
package led_display_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_KEY   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ALERT = 3'd4
  } sched_state_e;

  localparam logic [1:0] SRC_IDLE  = 2'd0;
  localparam logic [1:0] SRC_PLAY  = 2'd1;
  localparam logic [1:0] SRC_KEY   = 2'd2;
  localparam logic [1:0] SRC_ALERT = 2'd3;

  localparam logic [3:0] BLINK_LOW  = 4'h0;
  localparam logic [3:0] BLINK_HIGH = 4'hF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_display_sched_ms_tick_gen.sv
// Millisecond tick generator.
// Free-running prescaler counting 0..CLK_HZ/1000-1; ms_tick is high for the
// single cycle in which the prescaler sits at its last value, so the tick is
// acted upon by the edge that wraps the prescaler back to 0.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   ms_tick  out one-cycle pulse once per millisecond
module ms_tick_gen #(
  parameter int CLK_HZ = 27_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic ms_tick
);

  localparam int DIV   = CLK_HZ / 1000;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] prescale;

  assign ms_tick = (prescale == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
    end else if (ms_tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_display_sched.sv
// LED display scheduler: decides which requester drives the 6-LED display
// stage (4-bit value + pressed flag). Priority ALERT > KEY > HOLD > PLAY > IDLE,
// with a post-release hold time, timed alerts and an idle blink pattern.
// Requester inputs are registered first and all outputs are registered, so an
// input sampled at edge N shows on the outputs after edge N+1.
// Ports:
//   clk, sys_rst_n          clock, asynchronous active-low reset
//   key_valid, key_code     key scanner level request and code
//   play_valid, play_note   music player level request and note index
//   alert_req, alert_code   one-cycle alert request and its value
//   disp_data, disp_pressed value and pressed flag for the display stage
//   disp_src                owner: 0 idle, 1 play, 2 key/hold, 3 alert
//   alert_ack               one-cycle pulse on the cycle ALERT is entered
module led_display_sched
  import led_display_sched_pkg::*;
#(
  parameter int CLK_HZ   = 27_000_000,
  parameter int HOLD_MS  = 500,
  parameter int ALERT_MS = 1000,
  parameter int BLINK_MS = 250
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       play_valid,
  input  logic [3:0] play_note,
  input  logic       alert_req,
  input  logic [3:0] alert_code,
  output logic [3:0] disp_data,
  output logic       disp_pressed,
  output logic [1:0] disp_src,
  output logic       alert_ack
);

  localparam int TIMER_W = $clog2(max_int(HOLD_MS, ALERT_MS) + 1);
  localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  logic               ms_tick;
  logic               key_valid_q, play_valid_q;
  logic [3:0]         key_code_q, play_note_q, alert_code_q;
  logic               alert_pend, alert_take;
  sched_state_e       state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
  logic               blink_phase, blink_phase_nxt;
  logic [3:0]         last_code, last_code_nxt;
  logic [3:0]         data_nxt;
  logic               pressed_nxt, ack_nxt;
  logic [1:0]         src_nxt;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .ms_tick (ms_tick)
  );

  // Next-state logic. A pending alert preempts everything and reloads the
  // shared timer; otherwise the timer counts down on ms ticks and saturates
  // at 0, which is the expiry condition for HOLD and ALERT.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = (ms_tick && timer != '0) ? timer - TIMER_W'(1) : timer;
    alert_take = 1'b0;
    ack_nxt    = 1'b0;
    if (alert_pend) begin
      state_nxt  = ST_ALERT;
      timer_nxt  = TIMER_W'(ALERT_MS);
      alert_take = 1'b1;
      ack_nxt    = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid_q)       state_nxt = ST_KEY;
          else if (play_valid_q) state_nxt = ST_PLAY;
        end
        ST_PLAY: begin
          if (key_valid_q)        state_nxt = ST_KEY;
          else if (!play_valid_q) state_nxt = ST_IDLE;
        end
        ST_KEY: begin
          if (!key_valid_q) begin
            state_nxt = ST_HOLD;
            timer_nxt = TIMER_W'(HOLD_MS);
          end
        end
        ST_HOLD: begin
          // A key arriving on the expiry cycle still wins over PLAY/IDLE.
          if (key_valid_q)       state_nxt = ST_KEY;
          else if (timer == '0) begin
            if (play_valid_q)    state_nxt = ST_PLAY;
            else                 state_nxt = ST_IDLE;
          end
        end
        ST_ALERT: begin
          if (timer == '0) begin
            if (key_valid_q)       state_nxt = ST_KEY;
            else if (play_valid_q) state_nxt = ST_PLAY;
            else                   state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Blink counter restarts at phase 0 on every IDLE entry; while idle it counts
  // ms ticks and flips the phase every BLINK_MS of them. Outputs are decoded
  // from the next state so they land in the same edge as the state change.
  always_comb begin
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    if (state_nxt == ST_IDLE) begin
      if (state != ST_IDLE) begin
        blink_cnt_nxt   = '0;
        blink_phase_nxt = 1'b0;
      end else if (ms_tick) begin
        if (blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
          blink_cnt_nxt   = '0;
          blink_phase_nxt = ~blink_phase;
        end else begin
          blink_cnt_nxt = blink_cnt + BLINK_W'(1);
        end
      end
    end

    last_code_nxt = (state_nxt == ST_KEY) ? key_code_q : last_code;

    data_nxt    = BLINK_LOW;
    pressed_nxt = 1'b0;
    src_nxt     = SRC_IDLE;
    case (state_nxt)
      ST_ALERT: begin
        data_nxt = alert_code_q;
        src_nxt  = SRC_ALERT;
      end
      ST_KEY: begin
        data_nxt    = key_code_q;
        pressed_nxt = 1'b1;
        src_nxt     = SRC_KEY;
      end
      ST_HOLD: begin
        data_nxt = last_code;
        src_nxt  = SRC_KEY;
      end
      ST_PLAY: begin
        data_nxt = play_note_q;
        src_nxt  = SRC_PLAY;
      end
      default: begin
        data_nxt = blink_phase_nxt ? BLINK_HIGH : BLINK_LOW;
      end
    endcase
  end

  // A request arriving in the same cycle a pending alert is consumed stays
  // pending, so back-to-back requests each re-enter ALERT.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      play_valid_q <= 1'b0;
      play_note_q  <= '0;
      alert_pend   <= 1'b0;
      alert_code_q <= '0;
      state        <= ST_IDLE;
      timer        <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      last_code    <= '0;
      disp_data    <= '0;
      disp_pressed <= 1'b0;
      disp_src     <= SRC_IDLE;
      alert_ack    <= 1'b0;
    end else begin
      key_valid_q  <= key_valid;
      key_code_q   <= key_code;
      play_valid_q <= play_valid;
      play_note_q  <= play_note;
      alert_pend   <= alert_req | (alert_pend & ~alert_take);
      if (alert_req) alert_code_q <= alert_code;
      state        <= state_nxt;
      timer        <= timer_nxt;
      blink_cnt    <= blink_cnt_nxt;
      blink_phase  <= blink_phase_nxt;
      last_code    <= last_code_nxt;
      disp_data    <= data_nxt;
      disp_pressed <= pressed_nxt;
      disp_src     <= src_nxt;
      alert_ack    <= ack_nxt;
    end
  end

endmodule
